ysyx_24100005_dmem_responder: RTL and testbench
===============================================

# ysyx_24100005_dmem_responder

Memory-side responder for the core's load/store port: accepts one read or byte-masked write request at a time over a valid/ready request channel and returns the result over a valid/ready response channel after a configurable latency. Holds an internal word-addressed RAM mapped at `BASE`. It gives the multi-cycle core a synthesizable data memory to replace direct DPI memory calls.

## Interface
- `DEPTH_LOG2`, 12, log2 of RAM depth in 32-bit words (4096 words = 16 KiB).
- `BASE`, 32'h8000_0000, byte address of word 0.
- `LATENCY`, 2, wait cycles between accept and response; legal range 0..15.

- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data, lane-aligned (byte k on bits 8k+7:8k).
- `req_wmask`  in  4  byte strobes; bit k enables byte lane k.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  initiator takes the response.
- `rsp_rdata`  out  32  full aligned word read (reads); 0 for writes and errors.
- `rsp_err`  out  1  address outside `[BASE, BASE + 4*2^DEPTH_LOG2)`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, latch `wen`, `addr`, `wdata`, and `wmask`.
  - If `LATENCY` = 0, go to RESP. Otherwise load the counter with `LATENCY` and go to WAIT.
- WAIT:
  - `req_ready` = 0.
  - Decrement the counter each cycle.
  - When the counter equals 1, go to RESP on that edge.
- Entering RESP (the same edge that leaves IDLE or WAIT):
  - Compute the word index as `(addr - BASE) >> 2`. `addr[1:0]` is ignored; the initiator does lane extraction and sign extension.
  - In range, write: update each byte lane k where `wmask[k]` = 1. `rsp_rdata` = 0.
  - In range, read: `rsp_rdata` = RAM[index].
  - Out of range: no RAM update, `rsp_rdata` = 0, `rsp_err` = 1.
  - A write with `wmask` = 0 is legal. It changes nothing and returns `rsp_err` = 0 if in range.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_rdata` and `rsp_err` stay stable until `rsp_valid & rsp_ready`.
  - On that handshake, go to IDLE.
- Requests are never accepted outside IDLE. No pipelining; exactly one outstanding transaction.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State = IDLE, counter = 0.
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- Reset asserted mid-transaction aborts it.
  - A write not yet in RESP never commits.
  - A write already committed stays committed.
- Accept cycle A is the cycle whose rising edge samples `req_valid & req_ready` = 1.
- `rsp_valid` first reads high in cycle A+1+`LATENCY`.
- If `rsp_ready` is already 1, handshake happens in that cycle. `req_ready` returns to 1 in the following cycle.
- Minimum request-to-request spacing is `LATENCY` + 2 cycles.
- `req_ready` depends only on state, never combinationally on `req_valid`.
- `rsp_valid` depends only on state, never combinationally on `rsp_ready`.
- Read-after-write: a read accepted after a write's response handshake sees the written data.
- Address arithmetic is 32-bit unsigned.
  - Addresses below `BASE` are out of range (the subtraction wraps and the compare fails).
  - `BASE + 4*2^DEPTH_LOG2 - 4` is the last valid word address.
- Request inputs are ignored outside IDLE, even if `req_valid` = 1.

## Test plan
1. Reset values: hold `rst` = 0 for 3 cycles, then release. Required: `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0; no response appears while idle.
2. Write then read, `LATENCY` = 2:
   - Write `0x8000_0010` with `wdata` = 0xDEAD_BEEF, `wmask` = 4'hF. Required: `rsp_valid` in cycle A+3, `rsp_err` = 0.
   - Read the same address. Required: `rsp_rdata` = 0xDEAD_BEEF.
3. Byte mask: on that same word, write `wdata` = 0x0000_AA00 with `wmask` = 4'b0010. Required: a following read returns 0xDEAD_AAEF.
4. Range errors:
   - Read `0x7FFF_FFFC`. Required: `rsp_err` = 1, `rsp_rdata` = 0.
   - Write `0x8000_4000` (`DEPTH_LOG2` = 12). Required: `rsp_err` = 1, and a read of `0x8000_0000` is unchanged.
   - Read `0x8000_3FFC`. Required: `rsp_err` = 0.
5. Backpressure and `LATENCY` = 0:
   - Hold `rsp_ready` = 0 for 5 cycles during a read. Required: `rsp_valid`, `rsp_rdata`, and `rsp_err` stable; `req_ready` = 0 throughout; a new `req_valid` is ignored.
   - With `LATENCY` = 0 and `rsp_ready` = 1. Required: response in cycle A+1, next accept possible in cycle A+2.
6. Reset mid-operation: pre-fill the target word with 0x1111_1111. Accept a write of 0x5555_5555 to `0x8000_0020`, then pulse `rst` low during WAIT. Required: immediate IDLE, `rsp_valid` = 0, and a following read returns 0x1111_1111.

Source files
------------

// File: rtl/ysyx_24100005_dmem_responder.sv
// Data-memory responder: one read or byte-masked write at a time over valid/ready,
// answered after a fixed latency from an internal word-addressed RAM mapped at BASE.
module ysyx_24100005_dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    // state  | meaning
    // S_IDLE | ready for a request
    // S_WAIT | counting down the configured latency
    // S_RESP | response held until the initiator takes it
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH];

    logic        accept, commit;
    logic        op_wen;
    logic [31:0] op_addr, op_wdata, offset;
    logic [3:0]  op_wmask;
    logic        in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic        unused_offset;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end

    // With zero latency the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state_q == S_IDLE) begin
            op_wen   = req_wen_i;
            op_addr  = req_addr_i;
            op_wdata = req_wdata_i;
            op_wmask = req_wmask_i;
        end else begin
            op_wen   = wen_q;
            op_addr  = addr_q;
            op_wdata = wdata_q;
            op_wmask = wmask_q;
        end
        offset        = op_addr - BASE;
        in_range      = (offset[31:DEPTH_LOG2+2] == '0);
        idx           = offset[DEPTH_LOG2+1:2];
        unused_offset = ^offset[1:0];
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = !in_range;
            rdata_d = (in_range && !op_wen) ? mem_q[idx] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                wen_q   <= req_wen_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                wmask_q <= req_wmask_i;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM is intentionally not reset; a write lands only on the edge entering S_RESP.
    always_ff @(posedge clk_i) begin
        if (commit && in_range && op_wen) begin
            for (int k = 0; k < 4; k++) begin
                if (op_wmask[k]) mem_q[idx][8*k +: 8] <= op_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_dmem_responder.sv
// Self-checking bench: directed vector table, hand-written corner sequences, and
// random traffic checked against a byte-addressed memory model.
module tb_ysyx_24100005_dmem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] BYTES = 32'h0000_4000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        a_req_valid = 0, a_req_wen = 0, a_rsp_ready = 1;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0;
    logic [3:0]  a_req_wmask = 0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid = 0, b_req_wen = 0, b_rsp_ready = 1;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0;
    logic [3:0]  b_req_wmask = 0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    ysyx_24100005_dmem_responder #(.DEPTH_LOG2(12), .BASE(BASE), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_wen_i(a_req_wen),
        .req_addr_i(a_req_addr), .req_wdata_i(a_req_wdata), .req_wmask_i(a_req_wmask),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
    );

    ysyx_24100005_dmem_responder #(.DEPTH_LOG2(12), .BASE(BASE), .LATENCY(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_wen_i(b_req_wen),
        .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata), .req_wmask_i(b_req_wmask),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-addressed reference memory for the LATENCY=2 instance, keyed by byte offset from BASE.
    logic [7:0] mdl [int unsigned];

    task automatic model_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] mask, output logic [31:0] exp_rdata,
                             output logic exp_err, output logic known);
        logic [31:0] off;
        logic [31:0] word_off;
        off       = addr - BASE;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        known     = 1'b1;
        if (off >= BYTES) begin
            exp_err = 1'b1;
        end else begin
            word_off = off & ~32'd3;
            for (int k = 0; k < 4; k++) begin
                if (wen) begin
                    if (mask[k]) mdl[word_off + k] = wdata[8*k +: 8];
                end else if (mdl.exists(word_off + k)) begin
                    exp_rdata[8*k +: 8] = mdl[word_off + k];
                end else begin
                    known = 1'b0;
                end
            end
        end
    endtask

    // One complete transaction with rsp_ready held high; lat counts edges from accept to rsp_valid.
    task automatic txn(input int d, input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, output logic [31:0] rdata, output logic err,
                       output int lat);
        int guard = 0;
        @(negedge clk);
        while (!(d == 0 ? a_req_ready : b_req_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: req_ready stayed 0 for %0d cycles", guard);
        end
        if (d == 0) begin
            a_req_valid = 1; a_req_wen = wen; a_req_addr = addr; a_req_wdata = wdata;
            a_req_wmask = mask; a_rsp_ready = 1;
        end else begin
            b_req_valid = 1; b_req_wen = wen; b_req_addr = addr; b_req_wdata = wdata;
            b_req_wmask = mask; b_rsp_ready = 1;
        end
        @(posedge clk); #1;
        a_req_valid = 0; b_req_valid = 0;
        lat = 1;
        while (!(d == 0 ? a_rsp_valid : b_rsp_valid) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid never rose after %0d cycles", lat);
        end
        rdata = (d == 0) ? a_rsp_rdata : b_rsp_rdata;
        err   = (d == 0) ? a_rsp_err : b_rsp_err;
        @(posedge clk); #1;
        check("ready_after_hs", {31'b0, (d == 0 ? a_req_ready : b_req_ready)}, 32'd1);
        check("valid_after_hs", {31'b0, (d == 0 ? a_rsp_valid : b_rsp_valid)}, 32'd0);
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er, known;
        int          lat;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h0000_AA00, 4'h2, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[5]  = '{1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
        vecs[8]  = '{1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h8000_3FFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{1'b1, 32'h8000_0010, 32'h5A5A_5A5A, 4'h0, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_AAEF, 1'b0};

        // Reset values
        #1 rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", {31'b0, a_req_ready}, 32'd1);
            check("rst_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
            check("rst_rsp_rdata", a_rsp_rdata, 32'h0);
            check("rst_rsp_err",   {31'b0, a_rsp_err}, 32'd0);
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
            check("idle_req_ready", {31'b0, a_req_ready}, 32'd1);
        end

        // Directed vectors on the LATENCY=2 instance
        for (int i = 0; i < 12; i++) begin
            txn(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd, er, lat);
            model_txn(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].mask, exp_rd, exp_er, known);
            check($sformatf("vec%0d_lat", i),   lat, 32'd3);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i),   {31'b0, er}, {31'b0, vecs[i].exp_err});
        end

        // Backpressure: response held 5 cycles while a competing request is ignored
        @(negedge clk);
        a_req_valid = 1; a_req_wen = 0; a_req_addr = 32'h8000_0010; a_rsp_ready = 0;
        @(posedge clk); #1;
        a_req_wen = 1; a_req_wdata = 32'h0BAD_0BAD; a_req_wmask = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'b0, a_rsp_valid}, 32'd1);
            check("bp_rsp_rdata", a_rsp_rdata, 32'hDEAD_AAEF);
            check("bp_rsp_err",   {31'b0, a_rsp_err}, 32'd0);
            check("bp_req_ready", {31'b0, a_req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        a_req_valid = 0; a_rsp_ready = 1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'b0, a_rsp_valid}, 32'd0);
        check("bp_release_ready", {31'b0, a_req_ready}, 32'd1);
        txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
        check("bp_ignored_write", rd, 32'hDEAD_AAEF);

        // LATENCY=0: response in A+1, next accept in A+2
        @(negedge clk);
        b_req_valid = 1; b_req_wen = 1; b_req_addr = 32'h8000_0040;
        b_req_wdata = 32'h7654_3210; b_req_wmask = 4'hF; b_rsp_ready = 1;
        @(posedge clk); #1;
        check("l0_rsp_a1", {31'b0, b_rsp_valid}, 32'd1);
        check("l0_wr_err", {31'b0, b_rsp_err}, 32'd0);
        check("l0_busy",   {31'b0, b_req_ready}, 32'd0);
        b_req_wen = 0;
        @(posedge clk); #1;
        check("l0_ready_a2", {31'b0, b_req_ready}, 32'd1);
        check("l0_valid_a2", {31'b0, b_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        b_req_valid = 0;
        check("l0_rd_valid", {31'b0, b_rsp_valid}, 32'd1);
        check("l0_rd_data",  b_rsp_rdata, 32'h7654_3210);
        @(posedge clk); #1;
        check("l0_idle", {31'b0, b_rsp_valid}, 32'd0);
        txn(1, 1'b0, 32'h8000_4000, 32'h0, 4'h0, rd, er, lat);
        check("l0_err_lat", lat, 32'd1);
        check("l0_err",     {31'b0, er}, 32'd1);

        // Reset during WAIT aborts an uncommitted write
        txn(0, 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, rd, er, lat);
        model_txn(1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF, exp_rd, exp_er, known);
        @(negedge clk);
        a_req_valid = 1; a_req_wen = 1; a_req_addr = 32'h8000_0020;
        a_req_wdata = 32'h5555_5555; a_req_wmask = 4'hF;
        @(posedge clk); #1;
        a_req_valid = 0;
        check("mid_in_wait", {31'b0, a_req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("mid_rst_ready", {31'b0, a_req_ready}, 32'd1);
        check("mid_rst_valid", {31'b0, a_rsp_valid}, 32'd0);
        check("mid_rst_rdata", a_rsp_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        txn(0, 1'b0, 32'h8000_0020, 32'h0, 4'h0, rd, er, lat);
        check("mid_rst_nocommit", rd, 32'h1111_1111);

        // Random traffic against the byte model
        for (int i = 0; i < 80; i++) begin
            logic        w;
            logic [31:0] ad, wd;
            logic [3:0]  mk;
            int          r;
            r  = $urandom_range(0, 9);
            w  = 1'($urandom_range(0, 1));
            wd = $urandom;
            mk = 4'($urandom_range(0, 15));
            if (r == 0)      ad = BASE + BYTES + 32'(4 * $urandom_range(0, 255));
            else if (r == 1) ad = BASE - 32'(4 * $urandom_range(1, 64));
            else if (r == 2) ad = BASE + BYTES - 32'd4;
            else             ad = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            txn(0, w, ad, wd, mk, rd, er, lat);
            model_txn(w, ad, wd, mk, exp_rd, exp_er, known);
            check($sformatf("rnd%0d_lat", i), lat, 32'd3);
            check($sformatf("rnd%0d_err", i), {31'b0, er}, {31'b0, exp_er});
            if (known) check($sformatf("rnd%0d_rdata", i), rd, exp_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
